// File: rtl/icap_pkg.sv
// Shared definitions for the ICAP reboot sequencer.
// Holds the raw ICAP configuration words, the byte bit-reversal helpers that
// ICAP.I needs, the fixed part of the sequence length and the sequencer
// state type. No ports.
package icap_pkg;

  // Raw configuration words. These are the values before the per-byte bit swap.
  localparam logic [15:0] DUMMY     = 16'hFFFF;
  localparam logic [15:0] SYNC1     = 16'hAA99;
  localparam logic [15:0] SYNC2     = 16'h5566;
  localparam logic [15:0] WR_GEN1   = 16'h3261;
  localparam logic [15:0] WR_GEN2   = 16'h3281;
  localparam logic [15:0] WR_GEN3   = 16'h32A1;
  localparam logic [15:0] WR_GEN4   = 16'h32C1;
  localparam logic [15:0] WR_CMD    = 16'h30A1;
  localparam logic [15:0] CMD_IPROG = 16'h000E;
  localparam logic [15:0] NOOP      = 16'h2000;

  // Words before the NOOP padding: dummy, two sync words, four GENERAL
  // writes (header + payload each), and the CMD write carrying IPROG.
  localparam int unsigned SEQ_BASE_LEN = 13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_SEND   = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_t;

  // Reverse the bit order of one byte.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  // ICAP.I expects each byte bit-reversed; byte order itself is kept.
  function automatic logic [15:0] icap_swap(input logic [15:0] w);
    return {rev8(w[15:8]), rev8(w[7:0])};
  endfunction

endpackage

// File: rtl/icap_clk_div.sv
// Free-running ICAP clock generator.
// Toggles ICAP_CLK every CLK_DIV SYSCLK cycles and raises fall_stb for the one
// SYSCLK cycle whose closing edge drives ICAP_CLK from 1 to 0, so logic that
// updates on fall_stb changes on the same edge as the ICAP clock falls.
// Ports:
//   SYSCLK   in   system clock
//   RESET_N  in   asynchronous active-low reset
//   ICAP_CLK out  divided clock, 0 in reset
//   fall_stb out  one-cycle strobe ahead of each ICAP_CLK falling edge
module icap_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic SYSCLK,
  input  logic RESET_N,
  output logic ICAP_CLK,
  output logic fall_stb
);

  localparam int unsigned   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          clk_r;
  logic          clk_nxt_s;
  logic          stb_r;

  // Next value of the half-period counter and of the clock toggle
  always_comb begin
    cnt_nxt_s = cnt_r;
    clk_nxt_s = clk_r;
    if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = {CW{1'b0}};
      clk_nxt_s = ~clk_r;
    end else begin
      cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      clk_nxt_s = clk_r;
    end
  end

  // Divider state; the strobe is precomputed from next-state so it is
  // registered yet true exactly while clk_r is high on its last count.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r <= {CW{1'b0}};
      clk_r <= 1'b0;
      stb_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      clk_r <= clk_nxt_s;
      stb_r <= (cnt_nxt_s == CNT_MAX) && clk_nxt_s;
    end
  end

  assign ICAP_CLK = clk_r;
  assign fall_stb = stb_r;

endmodule

// File: rtl/icap_reboot_sequencer.sv
// Spartan-6 ICAP IPROG reboot sequencer.
// Accepts one reboot request (golden image or caller-supplied multiboot
// image), then streams dummy/sync, GENERAL1-4, CMD=IPROG and NOOP padding
// into ICAP, one word per ICAP_CLK period, and parks in a done state until
// reset. Requests are expected synchronous to SYSCLK.
// Ports:
//   SYSCLK          in   system clock
//   RESET_N         in   asynchronous active-low reset
//   BOOT_REQ        in   request multiboot image (pulse or level)
//   GOLDEN_REQ      in   request golden image (wins over BOOT_REQ)
//   MULTIBOOT_ADDR  in   24-bit flash byte address, sampled on accept
//   BUSY            out  request accepted (stays set until reset)
//   SEQ_DONE        out  sequence fully issued (sticky)
//   ICAP_CLK        out  ICAP clock, SYSCLK/(2*CLK_DIV)
//   ICAP_CE_N       out  ICAP chip enable, active low
//   ICAP_WE_N       out  ICAP write enable, active low
//   ICAP_I          out  ICAP data, bit-reversed within each byte
module icap_reboot_sequencer
  import icap_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter logic [23:0] GOLDEN_ADDR = 24'h000000,
  parameter logic [7:0]  FLASH_OP    = 8'h0B,
  parameter int unsigned NOOP_COUNT  = 2
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        BOOT_REQ,
  input  logic        GOLDEN_REQ,
  input  logic [23:0] MULTIBOOT_ADDR,
  output logic        BUSY,
  output logic        SEQ_DONE,
  output logic        ICAP_CLK,
  output logic        ICAP_CE_N,
  output logic        ICAP_WE_N,
  output logic [15:0] ICAP_I
);

  localparam int unsigned SEQ_LEN   = SEQ_BASE_LEN + NOOP_COUNT;
  localparam logic [4:0]  SEQ_LEN_W = 5'(SEQ_LEN);

  seq_state_t  state_r;
  logic [4:0]  idx_r;
  logic [15:0] tgt_lo_r;
  logic [15:0] tgt_hi_r;
  logic        busy_r;
  logic        done_r;
  logic        ce_n_r;
  logic        we_n_r;
  logic [15:0] icap_i_r;
  logic [15:0] word_s;
  logic        fall_stb_s;

  icap_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .SYSCLK   (SYSCLK),
    .RESET_N  (RESET_N),
    .ICAP_CLK (ICAP_CLK),
    .fall_stb (fall_stb_s)
  );

  // Raw word for the current index; anything past CMD/IPROG is NOOP padding
  always_comb begin
    word_s = NOOP;
    case (idx_r)
      5'd0:    word_s = DUMMY;
      5'd1:    word_s = SYNC1;
      5'd2:    word_s = SYNC2;
      5'd3:    word_s = WR_GEN1;
      5'd4:    word_s = tgt_lo_r;
      5'd5:    word_s = WR_GEN2;
      5'd6:    word_s = tgt_hi_r;
      5'd7:    word_s = WR_GEN3;
      5'd8:    word_s = GOLDEN_ADDR[15:0];
      5'd9:    word_s = WR_GEN4;
      5'd10:   word_s = {FLASH_OP, GOLDEN_ADDR[23:16]};
      5'd11:   word_s = WR_CMD;
      5'd12:   word_s = CMD_IPROG;
      default: word_s = NOOP;
    endcase
  end

  // Sequencer: arbitration in IDLE, then one word per fall_stb; idx_r always
  // points at the word to present on the next update point.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= ST_IDLE;
      idx_r    <= 5'd0;
      tgt_lo_r <= 16'h0000;
      tgt_hi_r <= 16'h0000;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ce_n_r   <= 1'b1;
      we_n_r   <= 1'b1;
      icap_i_r <= 16'hFFFF;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (GOLDEN_REQ) begin
            tgt_lo_r <= GOLDEN_ADDR[15:0];
            tgt_hi_r <= {FLASH_OP, GOLDEN_ADDR[23:16]};
            idx_r    <= 5'd0;
            busy_r   <= 1'b1;
            state_r  <= ST_ARM;
          end else if (BOOT_REQ) begin
            tgt_lo_r <= MULTIBOOT_ADDR[15:0];
            tgt_hi_r <= {FLASH_OP, MULTIBOOT_ADDR[23:16]};
            idx_r    <= 5'd0;
            busy_r   <= 1'b1;
            state_r  <= ST_ARM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARM: begin
          if (fall_stb_s) begin
            ce_n_r   <= 1'b0;
            we_n_r   <= 1'b0;
            icap_i_r <= icap_swap(word_s);
            idx_r    <= idx_r + 5'd1;
            state_r  <= ST_SEND;
          end else begin
            state_r <= ST_ARM;
          end
        end
        ST_SEND: begin
          if (fall_stb_s) begin
            if (idx_r == SEQ_LEN_W) begin
              ce_n_r   <= 1'b1;
              we_n_r   <= 1'b1;
              icap_i_r <= 16'hFFFF;
              done_r   <= 1'b1;
              state_r  <= ST_FINISH;
            end else begin
              icap_i_r <= icap_swap(word_s);
              idx_r    <= idx_r + 5'd1;
              state_r  <= ST_SEND;
            end
          end else begin
            state_r <= ST_SEND;
          end
        end
        ST_FINISH: begin
          state_r <= ST_FINISH;
        end
        default: begin
          // Unreachable encoding: release ICAP and fall back to idle.
          ce_n_r   <= 1'b1;
          we_n_r   <= 1'b1;
          icap_i_r <= 16'hFFFF;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY      = busy_r;
  assign SEQ_DONE  = done_r;
  assign ICAP_CE_N = ce_n_r;
  assign ICAP_WE_N = we_n_r;
  assign ICAP_I    = icap_i_r;

endmodule

// File: tb/tb_icap_reboot_sequencer.sv
// Self-checking bench for icap_reboot_sequencer: a CLK_DIV=4 instance and a
// CLK_DIV=1 instance share the stimulus; one of them is observed at a time.
module tb_icap_reboot_sequencer;

  localparam int          D0 = 4;
  localparam int          D1 = 1;
  localparam int          N0 = 2;
  localparam int          N1 = 3;
  localparam logic [23:0] G0 = 24'h000000;
  localparam logic [23:0] G1 = 24'h2A5C31;

  logic        SYSCLK;
  logic        RESET_N;
  logic        BOOT_REQ;
  logic        GOLDEN_REQ;
  logic [23:0] MULTIBOOT_ADDR;

  logic        busy0, done0, iclk0, ce0, we0;
  logic [15:0] i0;
  logic        busy1, done1, iclk1, ce1, we1;
  logic [15:0] i1;

  logic        sel;
  logic        obs_busy, obs_done, obs_clk, obs_ce, obs_we;
  logic [15:0] obs_i;

  int          cur_div;
  int          cur_noop;
  logic [23:0] cur_golden;

  int checks;
  int errors;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  icap_reboot_sequencer #(.CLK_DIV(D0), .GOLDEN_ADDR(G0), .FLASH_OP(8'h0B), .NOOP_COUNT(N0)) dut (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N), .BOOT_REQ(BOOT_REQ), .GOLDEN_REQ(GOLDEN_REQ),
    .MULTIBOOT_ADDR(MULTIBOOT_ADDR), .BUSY(busy0), .SEQ_DONE(done0), .ICAP_CLK(iclk0),
    .ICAP_CE_N(ce0), .ICAP_WE_N(we0), .ICAP_I(i0));

  icap_reboot_sequencer #(.CLK_DIV(D1), .GOLDEN_ADDR(G1), .FLASH_OP(8'h0B), .NOOP_COUNT(N1)) dut1 (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N), .BOOT_REQ(BOOT_REQ), .GOLDEN_REQ(GOLDEN_REQ),
    .MULTIBOOT_ADDR(MULTIBOOT_ADDR), .BUSY(busy1), .SEQ_DONE(done1), .ICAP_CLK(iclk1),
    .ICAP_CE_N(ce1), .ICAP_WE_N(we1), .ICAP_I(i1));

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  always_comb begin
    obs_busy = sel ? busy1 : busy0;
    obs_done = sel ? done1 : done0;
    obs_clk  = sel ? iclk1 : iclk0;
    obs_ce   = sel ? ce1 : ce0;
    obs_we   = sel ? we1 : we0;
    obs_i    = sel ? i1 : i0;
  end

  // Reference: ICAP.I carries each byte with its bits mirrored.
  function automatic logic [15:0] m_swap(input logic [15:0] w);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) r[(i / 8) * 8 + 7 - (i % 8)] = w[i];
    return r;
  endfunction

  // Reference word stream for a given target address.
  task automatic build_model(input logic [23:0] a);
    logic [15:0] hdr [13];
    hdr = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281, {8'h0B, a[23:16]},
            16'h32A1, cur_golden[15:0], 16'h32C1, {8'h0B, cur_golden[23:16]}, 16'h30A1, 16'h000E};
    exp_q.delete();
    for (int k = 0; k < 13; k++) exp_q.push_back(m_swap(hdr[k]));
    for (int k = 0; k < cur_noop; k++) exp_q.push_back(m_swap(16'h2000));
  endtask

  task automatic set_sel(input logic s);
    sel        = s;
    cur_div    = s ? D1 : D0;
    cur_noop   = s ? N1 : N0;
    cur_golden = s ? G1 : G0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; BOOT_REQ = 1'b0; GOLDEN_REQ = 1'b0;
    repeat (2) begin @(posedge SYSCLK); #1; end
    RESET_N = 1'b1;
    repeat ($urandom_range(1, 8)) begin @(posedge SYSCLK); #1; end
  endtask

  // Observes the selected DUT from the accept edge (cycle 1) onward.
  task automatic collect(input int max_cyc, input bit hold_req, input int poke_cyc, input int stop_words,
                         output int t0, output int td, output logic busy_acc, output int bad_chg,
                         output int clk_bad, output bit timed_out);
    logic pclk, pce, pwe, pdone;
    logic [15:0] pi;
    int run;
    bit seen;
    got_q.delete();
    t0 = -1; td = -1; busy_acc = 1'b0; bad_chg = 0; clk_bad = 0; timed_out = 1'b1;
    pclk = obs_clk; pce = obs_ce; pwe = obs_we; pdone = obs_done; pi = obs_i;
    run = 1; seen = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge SYSCLK); #1;
      if (c == 1) begin
        busy_acc = obs_busy;
        if (!hold_req) begin BOOT_REQ = 1'b0; GOLDEN_REQ = 1'b0; end
      end
      if (poke_cyc > 0 && c == poke_cyc) begin
        BOOT_REQ = 1'b1; GOLDEN_REQ = 1'b1; MULTIBOOT_ADDR = 24'($urandom);
      end
      if (poke_cyc > 0 && c == poke_cyc + 1) begin BOOT_REQ = 1'b0; GOLDEN_REQ = 1'b0; end
      if ((obs_i !== pi || obs_ce !== pce || obs_we !== pwe || obs_done !== pdone) &&
          !(pclk === 1'b1 && obs_clk === 1'b0)) bad_chg++;
      if (obs_clk === pclk) run++;
      else begin
        if (seen && run != cur_div) clk_bad++;
        seen = 1'b1; run = 1;
      end
      if (pclk === 1'b0 && obs_clk === 1'b1 && obs_ce === 1'b0) got_q.push_back(obs_i);
      if (t0 < 0 && obs_ce === 1'b0) t0 = c;
      pclk = obs_clk; pce = obs_ce; pwe = obs_we; pdone = obs_done; pi = obs_i;
      if (obs_done === 1'b1) begin td = c; timed_out = 1'b0; break; end
      if (stop_words > 0 && got_q.size() >= stop_words) begin timed_out = 1'b0; break; end
    end
    BOOT_REQ = 1'b0; GOLDEN_REQ = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({iclk0, ce0, we0, i0, busy0, done0} !== {1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_div4: got clk/ce/we/i/busy/done=%b%b%b %h %b%b required 011 ffff 00", iclk0, ce0, we0, i0, busy0, done0);
    end
    checks++;
    if ({iclk1, ce1, we1, i1, busy1, done1} !== {1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_div1: got clk/ce/we/i/busy/done=%b%b%b %h %b%b required 011 ffff 00", iclk1, ce1, we1, i1, busy1, done1);
    end
  endtask

  task automatic test_idle_quiet();
    int viol;
    viol = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      @(posedge SYSCLK); #1;
      if (ce0 !== 1'b1 || ce1 !== 1'b1 || we0 !== 1'b1 || we1 !== 1'b1 || busy0 !== 1'b0 || busy1 !== 1'b0) viol++;
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles required 0", viol); end
  endtask

  task automatic test_boot_plan();
    logic [15:0] plan [15];
    int t0, td, bad, cb;
    logic bz;
    bit to;
    plan = '{16'hFFFF, 16'h5599, 16'hAA66, 16'h4C86, 16'h0000, 16'h4C81, 16'hD018, 16'h4C85,
             16'h0000, 16'h4C83, 16'hD000, 16'h0C85, 16'h0070, 16'h0400, 16'h0400};
    set_sel(1'b0);
    do_reset();
    checks++;
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL plan_busy_pre: got %b required 0", obs_busy); end
    MULTIBOOT_ADDR = 24'h180000; BOOT_REQ = 1'b1;
    collect(3000, 1'b0, 0, 0, t0, td, bz, bad, cb, to);
    checks++;
    if (to) begin errors++; $display("FAIL plan_timeout: got no SEQ_DONE required SEQ_DONE"); end
    checks++;
    if (bz !== 1'b1) begin errors++; $display("FAIL plan_busy_accept: got %b required 1", bz); end
    checks++;
    if (got_q.size() != 15) begin errors++; $display("FAIL plan_len: got %0d required 15", got_q.size()); end
    for (int k = 0; k < 15; k++) begin
      logic [15:0] gv;
      gv = (k < got_q.size()) ? got_q[k] : 16'hxxxx;
      checks++;
      if (gv !== plan[k]) begin errors++; $display("FAIL plan_word%0d: got %h required %h", k, gv, plan[k]); end
    end
    checks++;
    if (t0 < 2 || t0 - 1 > 2 * D0 + 1) begin errors++; $display("FAIL plan_first_latency: got %0d required 1..%0d", t0 - 1, 2 * D0 + 1); end
    checks++;
    if (td - t0 != 15 * 2 * D0) begin errors++; $display("FAIL plan_done_time: got %0d required %0d", td - t0, 15 * 2 * D0); end
    checks++;
    if (bad != 0 || cb != 0) begin errors++; $display("FAIL plan_edges: got %0d off-fall changes, %0d bad half-periods required 0,0", bad, cb); end
    repeat (20) begin @(posedge SYSCLK); #1; end
    checks++;
    if ({obs_done, obs_busy, obs_ce, obs_we, obs_i} !== {1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL plan_finish: got done/busy/ce/we/i=%b%b%b%b %h required 1111 ffff", obs_done, obs_busy, obs_ce, obs_we, obs_i);
    end
  endtask

  task automatic test_golden_priority();
    int t0, td, bad, cb;
    logic bz;
    bit to;
    set_sel(1'b0);
    do_reset();
    MULTIBOOT_ADDR = 24'($urandom) | 24'h010101;
    BOOT_REQ = 1'b1; GOLDEN_REQ = 1'b1;
    build_model(cur_golden);
    collect(3000, 1'b0, 0, 0, t0, td, bz, bad, cb, to);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL gold_len: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      logic [15:0] gv;
      gv = (k < got_q.size()) ? got_q[k] : 16'hxxxx;
      checks++;
      if (gv !== exp_q[k]) begin errors++; $display("FAIL gold_word%0d: got %h required %h", k, gv, exp_q[k]); end
    end
    checks++;
    if (got_q.size() < 7 || got_q[4] !== 16'h0000 || got_q[6] !== 16'hD000) begin
      errors++; $display("FAIL gold_payload: got size %0d required GEN1=0000 GEN2=D000", got_q.size());
    end
  endtask

  task automatic test_mid_request();
    int t0, td, bad, cb;
    logic bz;
    bit to;
    logic [23:0] a;
    set_sel(1'b0);
    do_reset();
    a = 24'($urandom);
    MULTIBOOT_ADDR = a; BOOT_REQ = 1'b1;
    build_model(a);
    collect(3000, 1'b0, 60, 0, t0, td, bz, bad, cb, to);
    checks++;
    if (to || got_q.size() != 15) begin errors++; $display("FAIL mid_len: got %0d words (timeout=%0d) required 15", got_q.size(), to); end
    for (int k = 0; k < exp_q.size(); k++) begin
      logic [15:0] gv;
      gv = (k < got_q.size()) ? got_q[k] : 16'hxxxx;
      checks++;
      if (gv !== exp_q[k]) begin errors++; $display("FAIL mid_word%0d: got %h required %h", k, gv, exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int t0, td, bad, cb;
    logic bz;
    bit to;
    logic [23:0] a;
    set_sel(1'b0);
    do_reset();
    a = 24'($urandom);
    MULTIBOOT_ADDR = a; BOOT_REQ = 1'b1;
    build_model(a);
    collect(3000, 1'b0, 0, 7, t0, td, bz, bad, cb, to);
    checks++;
    if (to || got_q.size() != 7 || got_q[6] !== exp_q[6]) begin
      errors++; $display("FAIL rstmid_word6: got %0d words required 7 ending in %h", got_q.size(), exp_q[6]);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({iclk0, ce0, we0, i0, busy0, done0} !== {1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rstmid_async: got clk/ce/we/i/busy/done=%b%b%b %h %b%b required 011 ffff 00", iclk0, ce0, we0, i0, busy0, done0);
    end
    repeat (3) begin @(posedge SYSCLK); #1; end
    RESET_N = 1'b1;
    repeat ($urandom_range(1, 8)) begin @(posedge SYSCLK); #1; end
    a = 24'($urandom);
    MULTIBOOT_ADDR = a; BOOT_REQ = 1'b1;
    build_model(a);
    collect(3000, 1'b0, 0, 0, t0, td, bz, bad, cb, to);
    checks++;
    if (got_q.size() == 0 || got_q[0] !== 16'hFFFF) begin errors++; $display("FAIL rstmid_restart: got %0d words required first word ffff", got_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      logic [15:0] gv;
      gv = (k < got_q.size()) ? got_q[k] : 16'hxxxx;
      checks++;
      if (gv !== exp_q[k]) begin errors++; $display("FAIL rstmid_word%0d: got %h required %h", k, gv, exp_q[k]); end
    end
  endtask

  // Randomised runs on one instance: random target, request kind and pulse/level.
  task automatic test_random_runs(input logic s, input int runs, input string tag);
    int t0, td, bad, cb, len;
    logic bz;
    bit to, gold, hold;
    logic [23:0] a;
    set_sel(s);
    len = 13 + cur_noop;
    for (int r = 0; r < runs; r++) begin
      do_reset();
      a = 24'($urandom);
      gold = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      MULTIBOOT_ADDR = a;
      if (gold) GOLDEN_REQ = 1'b1; else BOOT_REQ = 1'b1;
      build_model(gold ? cur_golden : a);
      collect(3000, hold, 0, 0, t0, td, bz, bad, cb, to);
      checks++;
      if (to || bz !== 1'b1) begin errors++; $display("FAIL %s_run%0d_accept: got timeout=%0d busy=%b required 0,1", tag, r, to, bz); end
      checks++;
      if (got_q.size() != len) begin errors++; $display("FAIL %s_run%0d_len: got %0d required %0d", tag, r, got_q.size(), len); end
      for (int k = 0; k < exp_q.size(); k++) begin
        logic [15:0] gv;
        gv = (k < got_q.size()) ? got_q[k] : 16'hxxxx;
        checks++;
        if (gv !== exp_q[k]) begin errors++; $display("FAIL %s_run%0d_word%0d: got %h required %h", tag, r, k, gv, exp_q[k]); end
      end
      checks++;
      if (t0 < 2 || t0 - 1 > 2 * cur_div + 1) begin errors++; $display("FAIL %s_run%0d_latency: got %0d required 1..%0d", tag, r, t0 - 1, 2 * cur_div + 1); end
      checks++;
      if (td - t0 != len * 2 * cur_div) begin errors++; $display("FAIL %s_run%0d_done_time: got %0d required %0d", tag, r, td - t0, len * 2 * cur_div); end
      checks++;
      if (bad != 0 || cb != 0) begin errors++; $display("FAIL %s_run%0d_edges: got %0d off-fall changes, %0d bad half-periods required 0,0", tag, r, bad, cb); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    RESET_N = 1'b0; BOOT_REQ = 1'b0; GOLDEN_REQ = 1'b0; MULTIBOOT_ADDR = 24'h000000;
    set_sel(1'b0);
    #23;
    test_reset();
    test_idle_quiet();
    test_boot_plan();
    test_golden_priority();
    test_mid_request();
    test_reset_mid();
    test_random_runs(1'b1, 4, "div1");
    test_random_runs(1'b0, 4, "div4");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icap_reboot_sequencer.md
# icap_reboot_sequencer

- Drives the Spartan-6 ICAP primitive through a complete IPROG reconfiguration sequence, selecting between a caller-supplied multiboot image address and a fixed golden image address.
- Sits between the board-level request sources (front-panel button, host command) and the ICAP instance.
- Generates its own low-rate ICAP clock, arbitrates two requesters and emits the full word stream: sync, GENERAL1–4, CMD/IPROG, NOOP padding.

## Interface
- CLK_DIV, 4: SYSCLK cycles per ICAP_CLK half-period; ICAP_CLK = SYSCLK/(2*CLK_DIV), minimum 1.
- GOLDEN_ADDR, 24'h000000: SPI flash byte address of the golden image, written to GENERAL3/4.
- FLASH_OP, 8'h0B: SPI read opcode placed in GENERAL2[15:8] and GENERAL4[15:8].
- NOOP_COUNT, 2: trailing NOOP words after IPROG, range 1–15.
- SYSCLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- BOOT_REQ  in  1  request multiboot image; pulse or level.
- GOLDEN_REQ  in  1  request golden image; pulse or level.
- MULTIBOOT_ADDR  in  24  flash byte address of the multiboot image; sampled on accept.
- BUSY  out  1  sequence accepted and in progress or complete.
- SEQ_DONE  out  1  last NOOP issued; sticky until reset.
- ICAP_CLK  out  1  clock to ICAP.CLK.
- ICAP_CE_N  out  1  ICAP.CE, active low.
- ICAP_WE_N  out  1  ICAP.WRITE, active low.
- ICAP_I  out  16  ICAP.I, with bits reversed within each byte.

## Operation
- States: IDLE → ARM → SEND → FINISH. FINISH holds until reset; there is no return to IDLE.
- IDLE: requests are sampled every SYSCLK edge. GOLDEN_REQ wins over BOOT_REQ if both are high on the same edge.
  - On accept: latch target low = addr[15:0]; latch high = {FLASH_OP, addr[23:16]}.
  - addr = MULTIBOOT_ADDR for BOOT_REQ, GOLDEN_ADDR for GOLDEN_REQ.
  - Set BUSY and go to ARM.
- ARM: wait for the next ICAP_CLK falling update point, then enter SEND with word index 0.
- SEND issues 13+NOOP_COUNT words, one per ICAP_CLK period:
  - FFFF, AA99, 5566
  - 3261, target low
  - 3281, target high
  - 32A1, GOLDEN_ADDR[15:0]
  - 32C1, {FLASH_OP, GOLDEN_ADDR[23:16]}
  - 30A1, 000E
  - 2000 × NOOP_COUNT
- ICAP_I for each word = {rev8(w[15:8]), rev8(w[7:0])}. Example: AA99→5599, 5566→AA66, FFFF→FFFF.
- During SEND: ICAP_CE_N=0 and ICAP_WE_N=0. Both are set on the same update point as word 0.
- FINISH, at the update point after the last NOOP: CE_N=1, WE_N=1, ICAP_I=FFFF, SEQ_DONE=1, BUSY stays 1.
- Requests during ARM, SEND or FINISH are ignored. MULTIBOOT_ADDR changes after accept have no effect.
- Reset values: ICAP_CLK=0, ICAP_CE_N=1, ICAP_WE_N=1, ICAP_I=FFFF, BUSY=0, SEQ_DONE=0, state IDLE, divider 0.
- Reset asserted mid-SEND aborts immediately (asynchronous) to the reset values. No partial word is held.

## Timing
- ICAP_CLK is free-running from reset release. It is a registered toggle every CLK_DIV SYSCLK cycles.
- All ICAP outputs are registered and change only on the SYSCLK edge where ICAP_CLK goes 1→0. They are therefore stable for a full half-period before and after each ICAP rising edge.
- Accept to BUSY=1: 1 SYSCLK.
- Accept to first word on ICAP_I: ≤ 2*CLK_DIV+1 SYSCLK.
- Word n is valid for exactly 2*CLK_DIV SYSCLK cycles.
- SEQ_DONE rises (13+NOOP_COUNT)*2*CLK_DIV SYSCLK cycles after word 0 appears.
- CLK_DIV=1 is legal: ICAP_CLK = SYSCLK/2 and every other SYSCLK edge is an update point.

## Structure
- Shared package icap_pkg:
  - word constants: DUMMY, SYNC1, SYNC2, WR_GEN1..4, WR_CMD, CMD_IPROG, NOOP
  - rev8 and icap_swap functions
  - sequence-length localparam
  - state enum
- One sub-module, icap_clk_div. It holds the divider counter and toggle, and outputs ICAP_CLK plus a one-cycle fall_stb.
- The sequencer advances only on fall_stb.

## Test plan
- CLK_DIV=4, BOOT_REQ pulse with MULTIBOOT_ADDR=24'h180000 → ICAP_I samples at ICAP rising edges: FFFF, 5599, AA66, 4C86, 0000, 4C81, D018, 4C85, 0000, 4C83, D000, 0C85, 0070, 0400, 0400. Then SEQ_DONE=1, CE_N=1.
- GOLDEN_REQ and BOOT_REQ high on the same edge, GOLDEN_ADDR=0 → the GENERAL1 payload is 0000 and the GENERAL2 payload is D000 (golden wins).
- Second BOOT_REQ mid-SEND with new MULTIBOOT_ADDR → word stream unchanged and word count still 15.
- RESET_N low during word 6 → all outputs at reset values asynchronously. After release, a new BOOT_REQ restarts the stream from FFFF.
- CLK_DIV=1 → ICAP_CLK period is 2 SYSCLK, and each word holds exactly 2 SYSCLK with changes only on ICAP_CLK falling.
- Check that BUSY=1 one SYSCLK after accept and that no ICAP_CE_N low occurs while IDLE for 10k cycles with no requests.
